// File: rtl/reg128_fill_arbiter.sv
// Round-robin fill sequencer for a word-strobed frame buffer: one producer
// owns a whole frame, then the frame is held until the consumer accepts it.
module reg128_fill_arbiter #(
  parameter int BUF_W   = 128,
  parameter int WORD_W  = 8,
  localparam int NWORDS = BUF_W / WORD_W,
  localparam int IDX_W  = $clog2(NWORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [NWORDS-1:0] buf_we,
  output logic [WORD_W-1:0] buf_wdata,
  output logic [IDX_W-1:0]  word_idx,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              frame_src,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              fv_reg, fv_next;
  logic              src_reg, src_next;
  logic              last_reg, last_next;

  logic              word_fire;
  logic              last_word;
  logic [WORD_W-1:0] grant_data;

  // A word moves only while filling and only from the producer that owns the frame.
  assign word_fire  = (state_reg == FILL) && (src_reg ? req1_valid : req0_valid);
  assign grant_data = src_reg ? req1_data : req0_data;
  assign last_word  = (idx_reg == IDX_W'(NWORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      fv_reg    <= 1'b0;
      src_reg   <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      fv_reg    <= fv_next;
      src_reg   <= src_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    fv_next    = fv_reg;
    src_next   = src_reg;
    last_next  = last_reg;
    unique case (state_reg)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On contention the producer that did not fill the previous frame wins.
          if (req0_valid && req1_valid) src_next = ~last_reg;
          else                          src_next = req1_valid;
          idx_next   = '0;
          state_next = FILL;
        end
      end
      FILL: begin
        if (word_fire) begin
          if (last_word) begin
            idx_next   = '0;
            fv_next    = 1'b1;
            state_next = HOLD;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      HOLD: begin
        if (fv_reg && frame_ready) begin
          fv_next    = 1'b0;
          last_next  = src_reg;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        fv_next    = 1'b0;
      end
    endcase
  end

  always_comb begin
    req0_ready = (state_reg == FILL) && !src_reg;
    req1_ready = (state_reg == FILL) &&  src_reg;
    buf_we     = '0;
    buf_wdata  = '0;
    if (word_fire) begin
      buf_we    = NWORDS'(1) << idx_reg;
      buf_wdata = grant_data;
    end
    word_idx    = idx_reg;
    frame_valid = fv_reg;
    frame_src   = src_reg;
    busy        = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_reg128_fill_arbiter.sv
// Directed bench for reg128_fill_arbiter: a frame-level model predicts every
// output each cycle, plus literal checks of latency, buffer image and grant order.
module tb_reg128_fill_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]   req0_data = 8'h00, req1_data = 8'h80;
  logic         req0_ready, req1_ready;
  logic [15:0]  buf_we;
  logic [7:0]   buf_wdata;
  logic [3:0]   word_idx;
  logic         frame_valid;
  logic         frame_ready = 1'b0;
  logic         frame_src;
  logic         busy;

  reg128_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .buf_we(buf_we), .buf_wdata(buf_wdata), .word_idx(word_idx),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_src(frame_src), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Buffer of word registers, each gated only by its strobe, as the consumer sees it.
  logic [7:0] bufw [16];
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++)
      if (buf_we[k]) bufw[k] <= buf_wdata;
  end

  // Frame-level model: phase 0 = arbitrate, 1 = filling, 2 = holding.
  int         m_phase, m_cnt;
  logic       m_owner, m_last;
  logic [7:0] m_buf [16];
  int         n_phase, n_cnt;
  logic       n_owner, n_last, n_wr;
  int         n_wi;
  logic [7:0] n_wd;
  logic       e_hs;
  logic [15:0] e_we;
  logic [7:0]  e_wd;
  logic        src_log [$];

  function automatic logic [127:0] flat_bank(input logic [7:0] b [16]);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = b[k];
    return r;
  endfunction

  always @(negedge clk) begin
    n_wr = 1'b0; n_wi = 0; n_wd = 8'h00;
    if (rst) begin
      chk("rst_ready0", 128'(req0_ready), 128'(0));
      chk("rst_ready1", 128'(req1_ready), 128'(0));
      chk("rst_we", 128'(buf_we), 128'(0));
      chk("rst_wdata", 128'(buf_wdata), 128'(0));
      chk("rst_fv_busy_idx", {frame_valid, busy, frame_src, word_idx}, 128'(0));
      n_phase = 0; n_cnt = 0; n_owner = 1'b0; n_last = 1'b1;
    end else begin
      e_hs = (m_phase == 1) && (m_owner ? req1_valid : req0_valid);
      e_we = e_hs ? (16'h0001 << m_cnt) : 16'h0000;
      e_wd = e_hs ? (m_owner ? req1_data : req0_data) : 8'h00;
      chk("ready0", 128'(req0_ready), 128'((m_phase == 1) && !m_owner));
      chk("ready1", 128'(req1_ready), 128'((m_phase == 1) && m_owner));
      chk("buf_we", 128'(buf_we), 128'(e_we));
      chk("buf_wdata", 128'(buf_wdata), 128'(e_wd));
      chk("word_idx", 128'(word_idx), 128'(m_cnt));
      chk("frame_valid", 128'(frame_valid), 128'(m_phase == 2));
      chk("busy", 128'(busy), 128'(m_phase != 0));
      if (m_phase != 0) chk("frame_src", 128'(frame_src), 128'(m_owner));
      if (m_phase == 2) chk("buffer", flat_bank(bufw), flat_bank(m_buf));
      n_phase = m_phase; n_cnt = m_cnt; n_owner = m_owner; n_last = m_last;
      if (m_phase == 0) begin
        if (req0_valid || req1_valid) begin
          n_owner = (req0_valid && req1_valid) ? !m_last : req1_valid;
          n_phase = 1; n_cnt = 0;
        end
      end else if (m_phase == 1) begin
        if (e_hs) begin
          n_wr = 1'b1; n_wi = m_cnt; n_wd = e_wd;
          if (m_cnt == 15) begin n_phase = 2; n_cnt = 0; end
          else n_cnt = m_cnt + 1;
        end
      end else if (frame_ready) begin
        n_phase = 0; n_last = m_owner;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_cnt <= 0; m_owner <= 1'b0; m_last <= 1'b1;
    end else begin
      if (m_phase == 1 && n_phase == 2) src_log.push_back(m_owner);
      if (n_wr) m_buf[n_wi] <= n_wd;
      m_phase <= n_phase; m_cnt <= n_cnt; m_owner <= n_owner; m_last <= n_last;
    end
  end

  // Stimulus: each producer streams an incrementing counter, advanced on acceptance.
  logic h0, h1, gap1 = 1'b0;
  int   d0 = 0, d1 = 0;

  task automatic step();
    @(negedge clk);
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (h0) d0++;
    if (h1) d1++;
    req0_data = 8'(d0);
    req1_data = 8'(8'h80 + d1);
    if (gap1) req1_valid = !req1_valid;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    d0 = 0; d1 = 0;
    req0_data = 8'h00; req1_data = 8'h80;
    src_log.delete();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    // Frame from producer 0 alone, held 10 cycles before release.
    repeat (3) step();
    req0_valid = 1'b1;
    rst = 1'b0;
    chk("t1_ready_cycle1", 128'(req0_ready), 128'(0));
    step();
    chk("t1_ready_cycle2", 128'(req0_ready), 128'(1));
    n = 1;
    while (!frame_valid && n < 40) begin step(); n++; end
    chk("t1_fv_latency", 128'(n), 128'(17));
    chk("t1_src", 128'(frame_src), 128'(0));
    chk("t1_buffer", flat_bank(bufw), 128'h0F0E0D0C0B0A09080706050403020100);
    req0_valid = 1'b0;
    repeat (10) begin
      step();
      chk("t4_hold_fv", 128'(frame_valid), 128'(1));
    end
    frame_ready = 1'b1;
    step();
    chk("t4_release_idle", {busy, frame_valid}, 128'(0));

    // Both producers always requesting: grants must alternate.
    reset_dut();
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (src_log.size() < 4 && n < 200) begin step(); n++; end
    chk("t2_frames", 128'(src_log.size()), 128'(4));
    if (src_log.size() == 4) begin
      chk("t2_src0", 128'(src_log[0]), 128'(0));
      chk("t2_src1", 128'(src_log[1]), 128'(1));
      chk("t2_src2", 128'(src_log[2]), 128'(0));
      chk("t2_src3", 128'(src_log[3]), 128'(1));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Producer 1 alone with valid toggling every cycle.
    reset_dut();
    req1_valid = 1'b1; gap1 = 1'b1;
    n = 0;
    while (src_log.size() < 1 && n < 100) begin step(); n++; end
    gap1 = 1'b0; req1_valid = 1'b0;
    chk("t3_frames", 128'(src_log.size()), 128'(1));
    if (src_log.size() == 1) chk("t3_src", 128'(src_log[0]), 128'(1));
    chk("t3_words", 128'(d1), 128'(16));
    step();

    // Asynchronous reset in the middle of a fill.
    reset_dut();
    frame_ready = 1'b0;
    req0_valid = 1'b1;
    n = 0;
    while (word_idx != 4'd7 && n < 30) begin step(); n++; end
    chk("t5_reached_idx7", 128'(word_idx), 128'(7));
    rst = 1'b1;
    #1;
    chk("t5_async_idx", 128'(word_idx), 128'(0));
    chk("t5_async_busy", 128'(busy), 128'(0));
    chk("t5_async_ready", 128'(req0_ready), 128'(0));
    step();
    req1_valid = 1'b1;
    rst = 1'b0;
    step();
    chk("t5_regrant_src", 128'(frame_src), 128'(0));
    chk("t5_regrant_ready", {req0_ready, req1_ready, word_idx}, {122'd0, 2'b10, 4'd0});
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single requester repeating: always falls through to producer 0.
    reset_dut();
    frame_ready = 1'b1;
    req0_valid = 1'b1;
    n = 0;
    while (src_log.size() < 3 && n < 150) begin step(); n++; end
    chk("t6_frames", 128'(src_log.size()), 128'(3));
    for (int i = 0; i < src_log.size() && i < 3; i++)
      chk("t6_src", 128'(src_log[i]), 128'(0));
    req0_valid = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg128_fill_arbiter.md
Name: reg128_fill_arbiter

Overview:
- Sequences loading of the 128-bit register buffer, which is built from per-bit posedge registers with no enable of their own, gated here by per-word write strobes.
- Two word-wide producers compete for the buffer. A round-robin arbiter grants one producer an entire frame: NWORDS words, written in order from word 0 to word NWORDS-1.
- When the frame is complete the block presents it to the consumer through a valid/ready handshake. It holds off all writers until the consumer accepts.

Parameters:
- BUF_W, 128, total buffer width in bits.
- WORD_W, 8, producer word width; BUF_W must be an integer multiple of WORD_W.
- NWORDS, BUF_W/WORD_W (16), number of words per frame. Derived; do not override.
- IDX_W, $clog2(NWORDS) (4), width of word index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  producer 0 has a word.
- req0_data  in  WORD_W  producer 0 word.
- req0_ready  out  1  producer 0 word accepted this cycle when valid is also high.
- req1_valid  in  1  producer 1 has a word.
- req1_data  in  WORD_W  producer 1 word.
- req1_ready  out  1  producer 1 word accepted this cycle when valid is also high.
- buf_we  out  NWORDS  one-hot write strobe. Bit k enables buffer bits [k*WORD_W +: WORD_W].
- buf_wdata  out  WORD_W  data driven to the strobed word.
- word_idx  out  IDX_W  index of the next word to be written.
- frame_valid  out  1  buffer holds a complete frame.
- frame_ready  in  1  consumer accepts the frame.
- frame_src  out  1  producer that filled the current or held frame.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, word_idx=0, frame_valid=0, frame_src=0, last_src=1, so producer 0 wins the first arbitration.
  - All ready outputs 0, buf_we=0, buf_wdata=0, busy=0.
  - Buffer contents are not cleared.
- States: IDLE, FILL, HOLD.
- IDLE:
  - No ready asserted.
  - If one valid is high, grant that producer.
  - If both are high, grant the producer that is not last_src.
  - The grant registers frame_src. Next state is FILL, with word_idx=0.
  - Arbitration costs 1 cycle. The first word can be accepted at the earliest on the cycle after the request is seen.
- FILL:
  - reqN_ready=1 only for N==frame_src. The other ready stays 0.
  - On granted valid&ready (combinational in that cycle):
    - buf_we = 1<<word_idx; buf_wdata = granted data.
    - The buffer captures the word at the same clock edge.
    - word_idx increments at that edge.
  - Cycles with no handshake produce buf_we=0. word_idx holds and the grant is kept; there is no timeout.
  - When the handshake occurs at word_idx==NWORDS-1:
    - next state HOLD, frame_valid=1 from the next cycle.
    - word_idx wraps to 0.
- HOLD:
  - All ready=0, buf_we=0.
  - frame_valid stays 1 and the buffer is stable.
  - On frame_valid&frame_ready: frame_valid=0 at the edge, last_src=frame_src, next state IDLE.
  - frame_ready sampled outside HOLD is ignored.
- Minimum frame cycle:
  - 1 (arbitration) + NWORDS (fill) + 1 (HOLD, if frame_ready is already high).
  - Back-to-back frames are separated by the IDLE arbitration cycle.
- buf_wdata is 0 whenever buf_we==0.
- At most one buf_we bit is high in any cycle.
- Reset mid-FILL or mid-HOLD: abort to the reset state. Partially written words remain in the buffer but frame_valid stays 0.
- A valid from the non-granted producer during FILL or HOLD is held off, not dropped. That producer must keep valid high.

Test Plan:
- After reset, req0 only; 16 words 0x00..0x0F streamed with valid always high:
  - req0_ready asserts in cycle 2.
  - buf_we walks 0x0001..0x8000 with matching data.
  - frame_valid rises 1 cycle after the 16th word; frame_src=0.
  - Buffer reads 0x0F0E...0100.
- Both valid continuously, frame_ready tied high:
  - Frames alternate src 0,1,0,1.
  - req1_ready stays 0 throughout producer 0's frames, and req0_ready stays 0 throughout producer 1's.
- Producer 1 drops valid every other cycle mid-frame:
  - word_idx stalls, no buf_we pulses in gap cycles.
  - Frame completes after 16 accepted words.
- frame_ready held low for 10 cycles in HOLD:
  - frame_valid stays 1, all ready=0, buf_we=0.
  - Release frame_ready -> IDLE next cycle.
- rst pulse at word_idx=7:
  - All outputs return to reset values immediately.
  - The next grant goes to producer 0 and word_idx restarts at 0.
- Single requester repeating (req0 only, 3 frames):
  - Round-robin falls through to req0 each time, with src=0 on all three frames.
